// File: rtl/debug_vjtag_host_driver.sv
// Host-side virtual-JTAG initiator for the Nios II debug slave: runs one
// UIR/CDR/SDR/UDR/RTI scan per command and returns the captured tdo word.
module debug_vjtag_host_driver #(
    parameter int IR_W       = 2,
    parameter int DR_LEN     = 38,
    parameter int TCK_DIV    = 4,
    parameter int RTI_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IR_W-1:0]   cmd_ir,
    input  logic              cmd_skip_ir,
    input  logic [DR_LEN-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_LEN-1:0] rsp_data,
    output logic [IR_W-1:0]   rsp_ir_out,
    output logic              tck,
    output logic              tdi,
    input  logic              tdo,
    output logic [IR_W-1:0]   ir_in,
    input  logic [IR_W-1:0]   ir_out,
    output logic              vs_uir,
    output logic              vs_cdr,
    output logic              vs_sdr,
    output logic              vs_udr,
    output logic              jtag_state_rti
);

    // state | meaning
    // IDLE  | waiting for a command, tck parked low
    // UIR   | update-IR period, ir_in loaded, ir_out sampled
    // CDR   | capture-DR period
    // SDR   | DR_LEN shift periods, one bit per tck
    // UDR   | update-DR period
    // RTI   | RTI_CYCLES run-test-idle periods
    // DONE  | response held until rsp_ready
    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE
    } state_t;

    localparam int HALF  = TCK_DIV / 2;
    localparam int PH_W  = $clog2(TCK_DIV);
    localparam int BIT_W = $clog2(DR_LEN);
    localparam int RTI_W = $clog2(RTI_CYCLES + 1);

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [RTI_W-1:0]   rti_q, rti_d;
    logic [DR_LEN-1:0]  data_q;
    logic [DR_LEN-1:0]  rsp_data_q;
    logic [IR_W-1:0]    rsp_ir_out_q;
    logic [IR_W-1:0]    ir_in_q, ir_in_d;
    logic               tck_q, tck_d;
    logic               tdi_q, tdi_d;
    logic               vs_uir_q, vs_uir_d;
    logic               vs_cdr_q, vs_cdr_d;
    logic               vs_sdr_q, vs_sdr_d;
    logic               vs_udr_q, vs_udr_d;
    logic               rti_out_q, rti_out_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy, accept, sample, period_end, busy_d;

    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign accept = (state_q == S_IDLE) && cmd_valid;
    // Rising tck edge is the clk edge that ends the low half of the period.
    assign sample = busy && (phase_q == PH_W'(HALF - 1));

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        rti_d      = rti_q;
        phase_d    = '0;
        period_end = (phase_q == PH_W'(TCK_DIV - 1));
        if (busy && !period_end) begin
            phase_d = phase_q + 1'b1;
        end
        case (state_q)
            S_IDLE: if (cmd_valid) state_d = cmd_skip_ir ? S_CDR : S_UIR;
            S_UIR:  if (period_end) state_d = S_CDR;
            S_CDR: begin
                if (period_end) begin
                    state_d = S_SDR;
                    bit_d   = '0;
                end
            end
            S_SDR: begin
                if (period_end) begin
                    if (bit_q == BIT_W'(DR_LEN - 1)) state_d = S_UDR;
                    else                             bit_d   = bit_q + 1'b1;
                end
            end
            S_UDR: begin
                if (period_end) begin
                    state_d = S_RTI;
                    rti_d   = RTI_W'(RTI_CYCLES - 1);
                end
            end
            S_RTI: begin
                if (period_end) begin
                    if (rti_q == '0) state_d = S_DONE;
                    else             rti_d   = rti_q - 1'b1;
                end
            end
            S_DONE:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they only move on
        // the clk edge that opens phase 0 of a tck period.
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        tck_d       = busy_d && (phase_d >= PH_W'(HALF));
        vs_uir_d    = (state_d == S_UIR);
        vs_cdr_d    = (state_d == S_CDR);
        vs_sdr_d    = (state_d == S_SDR);
        vs_udr_d    = (state_d == S_UDR);
        rti_out_d   = (state_d == S_RTI);
        rsp_valid_d = (state_d == S_DONE);
        tdi_d       = (state_d == S_SDR) ? data_q[bit_d] : 1'b0;
        ir_in_d     = (accept && !cmd_skip_ir) ? cmd_ir : ir_in_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            bit_q        <= '0;
            rti_q        <= '0;
            data_q       <= '0;
            rsp_data_q   <= '0;
            rsp_ir_out_q <= '0;
            ir_in_q      <= '0;
            tck_q        <= 1'b0;
            tdi_q        <= 1'b0;
            vs_uir_q     <= 1'b0;
            vs_cdr_q     <= 1'b0;
            vs_sdr_q     <= 1'b0;
            vs_udr_q     <= 1'b0;
            rti_out_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            rti_q       <= rti_d;
            ir_in_q     <= ir_in_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            vs_uir_q    <= vs_uir_d;
            vs_cdr_q    <= vs_cdr_d;
            vs_sdr_q    <= vs_sdr_d;
            vs_udr_q    <= vs_udr_d;
            rti_out_q   <= rti_out_d;
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                data_q     <= cmd_data;
                rsp_data_q <= '0;
            end else if (sample) begin
                if (state_q == S_UIR) rsp_ir_out_q      <= ir_out;
                if (state_q == S_SDR) rsp_data_q[bit_q] <= tdo;
            end
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_ir_out     = rsp_ir_out_q;
    assign tck            = tck_q;
    assign tdi            = tdi_q;
    assign ir_in          = ir_in_q;
    assign vs_uir         = vs_uir_q;
    assign vs_cdr         = vs_cdr_q;
    assign vs_sdr         = vs_sdr_q;
    assign vs_udr         = vs_udr_q;
    assign jtag_state_rti = rti_out_q;

endmodule

// File: doc/debug_vjtag_host_driver.md
Name: debug_vjtag_host_driver

Overview:
- Host-side initiator for the Nios II debug-slave virtual-JTAG interface. It drives the ports the debug-slave tck/sysclk logic expects: tck, tdi, ir_in, and the virtual_state uir/cdr/sdr/udr and rti strobes.
- Takes one command at a time (IR value plus a DR_LEN-bit data word), runs the scan sequence UIR→CDR→SDR×DR_LEN→UDR→RTI, and returns the captured tdo word.
- Used for in-system self-test and for simulation benches that exercise the debug slave without a hardware JTAG cable.

Parameters:
- IR_W, 2, width of ir_in / ir_out.
- DR_LEN, 38, scan-chain length (bits shifted per command).
- TCK_DIV, 4, clk cycles per tck period; even, ≥2.
- RTI_CYCLES, 2, tck periods spent in run-test-idle after UDR; ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_ir  in  IR_W  instruction to load.
- cmd_skip_ir  in  1  1 = omit UIR phase; ir_in is kept.
- cmd_data  in  DR_LEN  data to shift, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DR_LEN  captured tdo bits; bit i = i-th bit shifted out.
- rsp_ir_out  out  IR_W  ir_out sampled during UIR.
- tck  out  1  generated scan clock.
- tdi  out  1  serial data to slave.
- tdo  in  1  serial data from slave.
- ir_in  out  IR_W  instruction register to slave.
- ir_out  in  IR_W  status from slave.
- vs_uir  out  1  update-IR strobe.
- vs_cdr  out  1  capture-DR strobe.
- vs_sdr  out  1  shift-DR level.
- vs_udr  out  1  update-DR strobe.
- jtag_state_rti  out  1  run-test-idle level.

Behaviour:
- Reset (synchronous, checked every clk edge, overrides everything):
  - state=IDLE, phase=0.
  - All outputs 0 except cmd_ready=1: tck, tdi, ir_in, vs_*, jtag_state_rti, rsp_valid, rsp_data, rsp_ir_out.
  - An in-flight command is dropped with no response.
- tck timing:
  - Each tck period = TCK_DIV clk cycles; phase counter 0..TCK_DIV-1.
  - tck=0 for phases 0..TCK_DIV/2-1 and tck=1 for the rest.
  - tck is held 0 in IDLE and DONE.
  - tdi, vs_*, jtag_state_rti and ir_in change only on the clk edge that starts phase 0.
  - tdo/ir_out are registered on the clk edge that ends phase TCK_DIV/2-1, i.e. coincident with the tck rising edge.
- Accept: cmd_valid && cmd_ready at edge N latches cmd_ir, cmd_skip_ir and cmd_data, and clears rsp_data. The first tck period starts in cycle N+1.
- State sequence, one tck period each unless noted:
  - UIR: vs_uir=1, ir_in=cmd_ir; ir_out sampled into rsp_ir_out. Skipped if cmd_skip_ir; rsp_ir_out then holds its previous value.
  - CDR: vs_cdr=1.
  - SDR, DR_LEN periods: vs_sdr=1, tdi=data[i] for i=0..DR_LEN-1. tdo sampled at each rise into rsp_data[i]; the bit-index counter is ceil(log2(DR_LEN)) wide.
  - UDR: vs_udr=1, tdi=0.
  - RTI, RTI_CYCLES periods: jtag_state_rti=1.
  - DONE: rsp_valid=1, all strobes 0. Held until rsp_ready=1, then → IDLE in the next cycle.
- Strobe and ir_in rules:
  - At most one vs_* strobe high in any cycle.
  - ir_in keeps its last loaded value indefinitely, cleared only by reset.
- Latency: rsp_valid is first high in cycle N+1+P·TCK_DIV, where P = (skip?0:1)+1+DR_LEN+1+RTI_CYCLES. With defaults and no skip, P=43, so rsp_valid first high at N+173.
- Handshake edges:
  - cmd_ready=0 in all states except IDLE; commands presented while busy are held by the requester (not lost, not accepted).
  - rsp_ready is ignored outside DONE.
  - rsp_valid && rsp_ready in DONE, with cmd_valid held: the new command is accepted no earlier than the cycle after the return to IDLE (one idle cycle minimum).
  - rsp_data and rsp_ir_out are stable while rsp_valid=1.

Test Plan:
- Reset then idle → all outputs 0, cmd_ready=1, tck static 0 for 100 cycles.
- Bench slave is a 38-bit shift register preloaded 0x3_0000_00A5, tdo=sr[0]. Send cmd_ir=2'b01, cmd_data=0x2_DEAD_BEEF, defaults → rsp_data=0x3_0000_00A5, the slave register holds 0x2_DEAD_BEEF at the vs_udr strobe, rsp_valid first high at accept+173, exactly 43 tck rises.
- cmd_skip_ir=1 after the ir=2'b10 command → no vs_uir pulse, ir_in stays 2'b10, 42 tck rises, rsp_valid at accept+169.
- Strobe/timing check on ir=2'b11 with ir_out driven 2'b01 → rsp_ir_out=2'b01; each vs_* exactly TCK_DIV cycles wide; tdi/vs_* never change while tck=1.
- Hold rsp_ready=0 for 50 cycles with cmd_valid=1 continuously → rsp_valid/rsp_data stable, cmd_ready=0; second command accepted exactly 2 cycles after the rsp_ready pulse.
- Assert reset during SDR bit 17 → next cycle all outputs 0, state IDLE, no rsp_valid; the next full command completes correctly.
